// File: rtl/systolic_feeder_pkg.sv
// rtl/systolic_feeder_pkg.sv - shared state encoding and array defaults for the feeder and collector
package systolic_feeder_pkg;

  localparam int ARRAY_N   = 5;
  localparam int DATA_SIZE = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_W = 3'd1;
  localparam logic [2:0] ST_FEED   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Cycles needed for the last partial sum to leave the bottom row of an n x n array.
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - job control, weight/activation streams and array-side outputs
interface systolic_feeder_if #(
  parameter int N  = systolic_feeder_pkg::ARRAY_N,
  parameter int DW = systolic_feeder_pkg::DATA_SIZE
);
  logic            start;
  logic [7:0]      num_vec;
  logic            w_valid;
  logic            w_ready;
  logic [N*DW-1:0] w_data;
  logic            a_valid;
  logic            a_ready;
  logic [N*DW-1:0] a_data;
  logic [N*DW-1:0] weight_bus;
  logic [N-1:0]    weight_en;
  logic [N*DW-1:0] left_data;
  logic [N-1:0]    left_valid;
  logic            go;
  logic            busy;
  logic            done;

  modport slave (
    input  start, num_vec, w_valid, w_data, a_valid, a_data,
    output w_ready, a_ready, weight_bus, weight_en, left_data, left_valid, go, busy, done
  );

  modport master (
    output start, num_vec, w_valid, w_data, a_valid, a_data,
    input  w_ready, a_ready, weight_bus, weight_en, left_data, left_valid, go, busy, done
  );
endinterface

// File: rtl/systolic_feeder_skew_line.sv
// rtl/systolic_feeder_skew_line.sv - DEPTH-stage data/valid shift register with sync clear and flush
module skew_line
  import systolic_feeder_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int DW    = DATA_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  output logic [DW-1:0] o_data,
  output logic          o_valid
);

  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
      r_valid <= '0;
    end else begin
      r_data[0]  <= i_data;
      r_valid[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign o_data  = r_data[DEPTH-1];
  assign o_valid = r_valid[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - weight preload, skewed activation feed and go/drain control for the PE array
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int N  = ARRAY_N,
  parameter int DW = DATA_SIZE
) (
  input logic              clk,
  input logic              rst,
  systolic_feeder_if.slave bus
);

  localparam int WCW = $clog2(N);
  localparam int DCW = $clog2(drain_cycles(N));
  localparam logic [WCW-1:0] W_LAST = WCW'(N - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(drain_cycles(N) - 1);

  logic [2:0]      r_state;
  logic [7:0]      r_num_vec;
  logic [7:0]      r_vcnt;
  logic [WCW-1:0]  r_wcnt;
  logic [DCW-1:0]  r_dcnt;
  logic [N*DW-1:0] r_weight_bus;
  logic [N-1:0]    r_weight_en;

  logic            w_w_fire;
  logic            w_a_fire;
  logic            w_flush;
  logic [N*DW-1:0] w_left_data;
  logic [N-1:0]    w_left_valid;

  assign w_w_fire = bus.w_valid && (r_state == ST_LOAD_W);
  assign w_a_fire = bus.a_valid && (r_state == ST_FEED);
  assign w_flush  = (r_state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_num_vec    <= '0;
      r_vcnt       <= '0;
      r_wcnt       <= '0;
      r_dcnt       <= '0;
      r_weight_bus <= '0;
      r_weight_en  <= '0;
    end else begin
      // weight_en is a single-cycle strobe following each accepted beat
      r_weight_en <= '0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_num_vec <= bus.num_vec;
            r_wcnt    <= '0;
            r_vcnt    <= '0;
            r_dcnt    <= '0;
            r_state   <= ST_LOAD_W;
          end
        end
        ST_LOAD_W: begin
          if (w_w_fire) begin
            r_weight_bus <= bus.w_data;
            r_weight_en  <= N'(1) << r_wcnt;
            if (r_wcnt == W_LAST) begin
              r_state <= (r_num_vec == 8'd0) ? ST_DONE : ST_FEED;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        ST_FEED: begin
          if (w_a_fire) begin
            r_vcnt <= r_vcnt + 8'd1;
            if (r_vcnt == r_num_vec - 8'd1) begin
              r_dcnt  <= '0;
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (r_dcnt == D_LAST) r_state <= ST_DONE;
          else                  r_dcnt  <= r_dcnt + 1'b1;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Row r sees its lane r cycles later than row 0, giving the diagonal wavefront.
  for (genvar g = 0; g < N; g++) begin : g_row
    logic [DW-1:0] w_lane;
    assign w_lane = w_a_fire ? bus.a_data[g*DW +: DW] : '0;

    skew_line #(
      .DEPTH (g + 1),
      .DW    (DW)
    ) u_line (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_data  (w_lane),
      .i_valid (w_a_fire),
      .o_data  (w_left_data[g*DW +: DW]),
      .o_valid (w_left_valid[g])
    );
  end

  assign bus.w_ready    = (r_state == ST_LOAD_W);
  assign bus.a_ready    = (r_state == ST_FEED);
  assign bus.go         = (r_state == ST_FEED) || (r_state == ST_DRAIN);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.weight_bus = r_weight_bus;
  assign bus.weight_en  = r_weight_en;
  assign bus.left_data  = w_left_data;
  assign bus.left_valid = w_left_valid;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - randomized job-level bench for systolic_feeder against a timeline model
module tb_systolic_feeder;
  import systolic_feeder_pkg::*;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int W  = N * DW;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_FEED  = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;
  localparam int P_END   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_if #(.N(N), .DW(DW)) bus ();

  systolic_feeder #(.N(N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int         b_cyc [N];
  logic [W-1:0] w_rows [N];
  int         n_beats;
  int         h_cyc [$];
  logic [W-1:0] a_vecs [$];
  logic [W-1:0] exp_wbus = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int r = 0; r < N; r++) v[r*DW +: DW] = 8'($urandom);
    return v;
  endfunction

  function automatic logic [W-1:0] pat_vec(input int j);
    logic [W-1:0] v;
    for (int r = 0; r < N; r++) v[r*DW +: DW] = 8'(10 * j + r);
    return v;
  endfunction

  function automatic logic [W-1:0] pat_row(input int k);
    logic [W-1:0] v;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = 8'((k + 1) * (c + 1));
    return v;
  endfunction

  // Phase of job cycle c, derived only from start (c=0), recorded beat and handshake cycles.
  function automatic int phase_at(input int c, input int nv);
    int d;
    if (c == 0) return P_IDLE;
    if (n_beats < N) return P_LOAD;
    if (nv == 0) return (c == b_cyc[N-1] + 1) ? P_DONE : P_END;
    if (h_cyc.size() < nv) return P_FEED;
    d = c - h_cyc[nv-1];
    if (d <= 2 * N - 1) return P_DRAIN;
    if (d == 2 * N) return P_DONE;
    return P_END;
  endfunction

  task automatic check_cycle(input int c, input int ph);
    logic [N-1:0] e_en;
    logic [W-1:0] e_ld;
    logic [N-1:0] e_lv;
    e_en = '0;
    e_ld = '0;
    e_lv = '0;
    for (int k = 0; k < n_beats; k++) if (b_cyc[k] == c - 1) e_en[k] = 1'b1;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < h_cyc.size(); j++)
        if (h_cyc[j] + r + 1 == c) begin
          e_ld[r*DW +: DW] = a_vecs[j][r*DW +: DW];
          e_lv[r] = 1'b1;
        end
    check_val($sformatf("c%0d w_ready", c), 64'(bus.w_ready), 64'(ph == P_LOAD));
    check_val($sformatf("c%0d a_ready", c), 64'(bus.a_ready), 64'(ph == P_FEED));
    check_val($sformatf("c%0d go", c), 64'(bus.go), 64'(ph == P_FEED || ph == P_DRAIN));
    check_val($sformatf("c%0d busy", c), 64'(bus.busy), 64'(ph >= P_LOAD && ph <= P_DONE));
    check_val($sformatf("c%0d done", c), 64'(bus.done), 64'(ph == P_DONE));
    check_val($sformatf("c%0d weight_en", c), 64'(bus.weight_en), 64'(e_en));
    check_val($sformatf("c%0d weight_bus", c), 64'(bus.weight_bus), 64'(exp_wbus));
    check_val($sformatf("c%0d left_data", c), 64'(bus.left_data), 64'(e_ld));
    check_val($sformatf("c%0d left_valid", c), 64'(bus.left_valid), 64'(e_lv));
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, " weight_bus"}, 64'(bus.weight_bus), 64'(0));
    check_val({tag, " weight_en"}, 64'(bus.weight_en), 64'(0));
    check_val({tag, " left_data"}, 64'(bus.left_data), 64'(0));
    check_val({tag, " left_valid"}, 64'(bus.left_valid), 64'(0));
    check_val({tag, " go"}, 64'(bus.go), 64'(0));
    check_val({tag, " busy"}, 64'(bus.busy), 64'(0));
    check_val({tag, " done"}, 64'(bus.done), 64'(0));
    check_val({tag, " w_ready"}, 64'(bus.w_ready), 64'(0));
    check_val({tag, " a_ready"}, 64'(bus.a_ready), 64'(0));
  endtask

  // wmode: 0 steady beats, 1 random gaps, 2 two idle cycles after beat index 2.
  // amode: 0 back to back, 1 one bubble after vector 0, 2 random gaps.
  task automatic run_job(input int nv, input int wmode, input int amode, input bit pat,
                         input bit noise, input int abort_hs);
    int ph;
    int gap;
    bit wv, av, bubbled, fin, aborting;
    logic [W-1:0] vec;
    n_beats  = 0;
    h_cyc.delete();
    a_vecs.delete();
    gap      = 0;
    bubbled  = 0;
    fin      = 0;
    aborting = 0;
    for (int k = 0; k < N; k++) w_rows[k] = pat ? pat_row(k) : rand_word();
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(posedge clk);
      #1;
      ph = phase_at(c, nv);
      bus.start   = (c == 0) || (noise && (ph == P_FEED || ph == P_DRAIN) && ($urandom_range(0, 1) == 1));
      bus.num_vec = (c == 0) ? nv[7:0] : 8'($urandom);
      wv = 1'b0;
      if (ph == P_LOAD) begin
        if (gap > 0) gap--;
        else wv = (wmode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      end else begin
        wv = ($urandom_range(0, 1) == 1);
      end
      bus.w_valid = wv;
      bus.w_data  = (ph == P_LOAD && wv) ? w_rows[n_beats] : rand_word();
      av  = 1'b0;
      vec = pat ? pat_vec(h_cyc.size()) : rand_word();
      if (ph == P_FEED) begin
        if (amode == 1 && h_cyc.size() == 1 && !bubbled) bubbled = 1'b1;
        else if (amode == 2) av = ($urandom_range(0, 3) != 0);
        else av = 1'b1;
        if (abort_hs >= 0 && h_cyc.size() == abort_hs) begin
          av       = 1'b0;
          aborting = 1'b1;
          rst      = 1'b0;
        end
      end else begin
        av = ($urandom_range(0, 1) == 1);
      end
      bus.a_valid = av;
      bus.a_data  = (ph == P_FEED && av) ? vec : rand_word();
      @(negedge clk);
      check_cycle(c, ph);
      if (ph == P_LOAD && wv) begin
        b_cyc[n_beats] = c;
        exp_wbus = w_rows[n_beats];
        if (wmode == 2 && n_beats == 2) gap = 2;
        n_beats++;
      end
      if (ph == P_FEED && av) begin
        h_cyc.push_back(c);
        a_vecs.push_back(vec);
      end
      if (ph == P_END) fin = 1'b1;
      if (aborting) begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.start   = 1'b0;
        bus.w_valid = 1'b0;
        bus.a_valid = 1'b0;
        exp_wbus = '0;
        @(negedge clk);
        check_quiet("abort");
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check_val("abort busy", 64'(bus.busy), 64'(0));
          check_val("abort done", 64'(bus.done), 64'(0));
        end
        fin = 1'b1;
      end
    end
    if (!fin) check_val("job_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.num_vec = '0;
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
    bus.a_valid = 1'b0;
    bus.a_data  = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    run_job(3, 2, 0, 1'b1, 1'b0, -1);
    run_job(3, 0, 1, 1'b1, 1'b0, -1);
    run_job(0, 0, 0, 1'b0, 1'b0, -1);
    run_job(4, 1, 2, 1'b0, 1'b1, -1);
    run_job(6, 0, 2, 1'b0, 1'b0, 2);
    run_job(5, 1, 2, 1'b0, 1'b0, -1);
    run_job(1, 0, 0, 1'b0, 1'b1, -1);
    for (int i = 0; i < 6; i++) run_job($urandom_range(0, 12), 1, 2, 1'b0, 1'(i % 2), -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
